mem_arbiter_rr: RTL and testbench

//  Parametrised N-core shared-memory arbiter; generalises the single grant line of the dual-core system to NCORES cores.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_if.sv | 37 +++
 rtl/rr_picker.sv | 33 +++
 rtl/mem_arbiter_rr.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM state encoding,
// a constant-evaluable clog2 and the index width of the default configuration.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so that index vectors always have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int ARB_DEF_NCORES = 2;
  localparam int ARB_DEF_IDXW   = clog2(ARB_DEF_NCORES);

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Core-array / memory bus seen by the round-robin arbiter. The master modport is
// the arbiter itself; the slave modport is the environment (cores plus memory).
interface mem_arbiter_rr_if import arb_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int NCORES = 2
) ();

  localparam int IDXW = clog2(NCORES);

  logic [NCORES-1:0]       core_read;
  logic [NCORES-1:0]       core_write;
  logic [NCORES*WIDTH-1:0] core_adr;
  logic [NCORES*WIDTH-1:0] core_wdata;
  logic [NCORES-1:0]       grant;
  logic [WIDTH-1:0]        core_rdata;
  logic                    mem_read;
  logic                    mem_write;
  logic [WIDTH-1:0]        mem_adr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH-1:0]        mem_rdata;
  logic [IDXW-1:0]         owner;
  logic                    busy;
  logic                    timeout;

  modport master (
    input  core_read, core_write, core_adr, core_wdata, mem_rdata,
    output grant, core_rdata, mem_read, mem_write, mem_adr, mem_wdata,
           owner, busy, timeout
  );

  modport slave (
    output core_read, core_write, core_adr, core_wdata, mem_rdata,
    input  grant, core_rdata, mem_read, mem_write, mem_adr, mem_wdata,
           owner, busy, timeout
  );

endinterface

// File: rtl/rr_picker.sv
// Rotating-priority encoder: finds the first set request after the last pointer,
// wrapping around, and returns it as one-hot, as an index and as an any flag.
module rr_picker import arb_pkg::*; #(
  parameter int NCORES = 2
) (
  input  logic [NCORES-1:0]        req,
  input  logic [clog2(NCORES)-1:0] last,
  output logic [NCORES-1:0]        pick,
  output logic [clog2(NCORES)-1:0] idx,
  output logic                     any
);

  localparam int IDXW = clog2(NCORES);

  // Scan offsets 1..NCORES from the last pointer; the first hit wins.
  always_comb begin
    int   c_s;
    logic hit_s;
    pick  = '0;
    idx   = '0;
    any   = 1'b0;
    c_s   = 0;
    hit_s = 1'b0;
    for (int k = 1; k <= NCORES; k++) begin
      c_s     = (int'(last) + k) % NCORES;
      hit_s   = req[c_s] & ~any;
      pick[c_s] = pick[c_s] | hit_s;
      idx     = hit_s ? IDXW'(c_s) : idx;
      any     = any | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-core round-robin shared-memory arbiter with owner-held multicycle tenures.
// Define ARB_TIMEOUT_EN to add the MAXHOLD forced-release hold counter.
module mem_arbiter_rr import arb_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int NCORES  = 2,
  parameter int MAXHOLD = 16
) (
  input logic               clk,
  input logic               reset,
  mem_arbiter_rr_if.master  bus
);

  localparam int IDXW = clog2(NCORES);

  arb_state_e        state_r, state_n;
  logic [NCORES-1:0] grant_r, grant_n;
  logic [NCORES-1:0] req_s, cand_s, pick_s;
  logic [IDXW-1:0]   owner_r, owner_n, last_r, last_n, idx_s;
  logic              any_s, own_req_s, force_s;
  logic              timeout_r, timeout_n;
  logic              mem_read_s, mem_write_s;
  logic [WIDTH-1:0]  mem_adr_s, mem_wdata_s;

  assign req_s     = bus.core_read | bus.core_write;
  // The current owner is masked out so a forced release always hands over.
  assign cand_s    = req_s & ~grant_r;
  assign own_req_s = |(req_s & grant_r);

  rr_picker #(.NCORES(NCORES)) u_pick (
    .req  (cand_s),
    .last (last_r),
    .pick (pick_s),
    .idx  (idx_s),
    .any  (any_s)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int              HOLDW    = clog2(MAXHOLD) + 1;
  localparam logic [HOLDW-1:0] HOLD_LIM = HOLDW'(MAXHOLD - 1);

  logic [HOLDW-1:0] hold_r, hold_n;
  logic             new_grant_s;

  assign new_grant_s = (grant_n != grant_r) & (|grant_n);
  assign force_s     = (state_r == ARB_OWNED) & (hold_r == HOLD_LIM) & any_s;

  // Owned-cycle count: restarts on each new grant, saturates at MAXHOLD-1.
  always_comb begin
    hold_n = hold_r;
    if (new_grant_s) begin
      hold_n = '0;
    end else if ((state_r == ARB_OWNED) && (hold_r != HOLD_LIM)) begin
      hold_n = hold_r + 1'b1;
    end else if (state_r == ARB_OWNED) begin
      hold_n = hold_r;
    end else begin
      hold_n = '0;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r <= '0;
    end else begin
      hold_r <= hold_n;
    end
  end
`else
  assign force_s = 1'b0;
`endif

  // Next-state logic: grant, owner and last pointer move together on a handover.
  always_comb begin
    state_n   = state_r;
    grant_n   = grant_r;
    owner_n   = owner_r;
    last_n    = last_r;
    timeout_n = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (any_s) begin
          state_n = ARB_OWNED;
          grant_n = pick_s;
          owner_n = idx_s;
          last_n  = idx_s;
        end else begin
          state_n = ARB_IDLE;
        end
      end
      ARB_OWNED: begin
        if (!own_req_s && any_s) begin
          grant_n = pick_s;
          owner_n = idx_s;
          last_n  = idx_s;
        end else if (!own_req_s) begin
          state_n = ARB_IDLE;
          grant_n = '0;
        end else if (force_s) begin
          grant_n   = pick_s;
          owner_n   = idx_s;
          last_n    = idx_s;
          timeout_n = 1'b1;
        end else begin
          state_n = ARB_OWNED;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ARB_IDLE;
      grant_r   <= '0;
      owner_r   <= '0;
      last_r    <= IDXW'(NCORES - 1);
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      grant_r   <= grant_n;
      owner_r   <= owner_n;
      last_r    <= last_n;
      timeout_r <= timeout_n;
    end
  end

  // Forward the owner's request to memory; write wins over a simultaneous read.
  always_comb begin
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    mem_adr_s   = '0;
    mem_wdata_s = '0;
    if (state_r == ARB_OWNED) begin
      mem_write_s = bus.core_write[owner_r];
      mem_read_s  = bus.core_read[owner_r] & ~bus.core_write[owner_r];
      mem_adr_s   = bus.core_adr[int'(owner_r) * WIDTH +: WIDTH];
      mem_wdata_s = bus.core_wdata[int'(owner_r) * WIDTH +: WIDTH];
    end else begin
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
    end
  end

  assign bus.grant      = grant_r;
  assign bus.owner      = owner_r;
  assign bus.busy       = (state_r == ARB_OWNED);
  assign bus.timeout    = timeout_r;
  assign bus.mem_read   = mem_read_s;
  assign bus.mem_write  = mem_write_s;
  assign bus.mem_adr    = mem_adr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.core_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 2-core table plus hand sequences for
// timeout, async reset mid-tenure and 4-core rotation order.
module tb_mem_arbiter_rr;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] rd;
    logic [1:0] wr;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] rdat;
    logic [1:0] g;
    logic       o;
    logic       b;
    logic       mr;
    logic       mw;
    logic [7:0] ma;
    logic [7:0] mwd;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t tbl [15];

  mem_arbiter_rr_if #(.WIDTH(8), .NCORES(2)) bus2 ();
  mem_arbiter_rr_if #(.WIDTH(8), .NCORES(4)) bus4 ();

  mem_arbiter_rr #(.WIDTH(8), .NCORES(2), .MAXHOLD(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  mem_arbiter_rr #(.WIDTH(8), .NCORES(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] rd, input logic [1:0] wr,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] rdat, input logic [1:0] g,
                               input logic o, input logic b, input logic mr,
                               input logic mw, input logic [7:0] ma,
                               input logic [7:0] mwd);
    vec_t v;
    v = {rd, wr, a0, a1, w0, w1, rdat, g, o, b, mr, mw, ma, mwd};
    return v;
  endfunction

  task automatic drive2(input logic [1:0] rd, input logic [1:0] wr);
    bus2.core_read  = rd;
    bus2.core_write = wr;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //                rd     wr     a0     a1     w0     w1     rdat   g      o     b     mr    mw    ma     mwd
    tbl[0]  = mkv(2'b11, 2'b00, 8'h10, 8'h20, 8'h01, 8'h02, 8'h5A, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h01);
    tbl[1]  = mkv(2'b11, 2'b00, 8'h11, 8'h21, 8'h01, 8'h02, 8'h5B, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h01);
    tbl[2]  = mkv(2'b11, 2'b00, 8'h12, 8'h22, 8'h01, 8'h02, 8'h5C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h01);
    tbl[3]  = mkv(2'b10, 2'b00, 8'h13, 8'h23, 8'h01, 8'h02, 8'h5D, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h23, 8'h02);
    tbl[4]  = mkv(2'b11, 2'b00, 8'h14, 8'h24, 8'h01, 8'h02, 8'h5E, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h24, 8'h02);
    tbl[5]  = mkv(2'b11, 2'b00, 8'h15, 8'h25, 8'h01, 8'h02, 8'h5F, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h25, 8'h02);
    tbl[6]  = mkv(2'b01, 2'b00, 8'h16, 8'h26, 8'h01, 8'h02, 8'h60, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h16, 8'h01);
    tbl[7]  = mkv(2'b00, 2'b10, 8'h16, 8'h3C, 8'h01, 8'hA5, 8'h61, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 8'hA5);
    tbl[8]  = mkv(2'b01, 2'b10, 8'h55, 8'h3C, 8'h01, 8'hA5, 8'h62, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 8'hA5);
    tbl[9]  = mkv(2'b11, 2'b10, 8'h55, 8'h3C, 8'h01, 8'hA5, 8'h63, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 8'hA5);
    tbl[10] = mkv(2'b00, 2'b00, 8'h55, 8'h3C, 8'h01, 8'hA5, 8'h64, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tbl[11] = mkv(2'b00, 2'b01, 8'h77, 8'h3C, 8'hC3, 8'hA5, 8'h65, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'hC3);
    tbl[12] = mkv(2'b00, 2'b00, 8'h77, 8'h3C, 8'hC3, 8'hA5, 8'h66, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tbl[13] = mkv(2'b11, 2'b00, 8'h10, 8'h20, 8'h01, 8'h02, 8'h67, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 8'h02);
    tbl[14] = mkv(2'b00, 2'b00, 8'h10, 8'h20, 8'h01, 8'h02, 8'h68, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset held while every core requests
    reset = 1'b1;
    drive2(2'b11, 2'b00);
    bus2.core_adr   = {8'h20, 8'h10};
    bus2.core_wdata = {8'h02, 8'h01};
    bus2.mem_rdata  = 8'h00;
    bus4.core_read  = 4'b0000;
    bus4.core_write = 4'b0000;
    bus4.core_adr   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus4.core_wdata = 32'h0;
    bus4.mem_rdata  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst grant",    32'(bus2.grant),    32'h0);
    chk("rst mem_read", 32'(bus2.mem_read), 32'h0);
    chk("rst busy",     32'(bus2.busy),     32'h0);
    chk("rst owner",    32'(bus2.owner),    32'h0);
    chk("rst grant4",   32'(bus4.grant),    32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive2(tbl[i].rd, tbl[i].wr);
      bus2.core_adr   = {tbl[i].a1, tbl[i].a0};
      bus2.core_wdata = {tbl[i].w1, tbl[i].w0};
      bus2.mem_rdata  = tbl[i].rdat;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d grant", i),     32'(bus2.grant),      32'(tbl[i].g));
      chk($sformatf("v%0d owner", i),     32'(bus2.owner),      32'(tbl[i].o));
      chk($sformatf("v%0d busy", i),      32'(bus2.busy),       32'(tbl[i].b));
      chk($sformatf("v%0d mem_read", i),  32'(bus2.mem_read),   32'(tbl[i].mr));
      chk($sformatf("v%0d mem_write", i), 32'(bus2.mem_write),  32'(tbl[i].mw));
      chk($sformatf("v%0d mem_adr", i),   32'(bus2.mem_adr),    32'(tbl[i].ma));
      chk($sformatf("v%0d mem_wdata", i), 32'(bus2.mem_wdata),  32'(tbl[i].mwd));
      chk($sformatf("v%0d core_rdata", i), 32'(bus2.core_rdata), 32'(tbl[i].rdat));
      chk($sformatf("v%0d timeout", i),   32'(bus2.timeout),    32'h0);
      @(negedge clk);
    end

    // Core 0 takes the bus, then core 1 contends while core 0 keeps requesting
    bus2.core_adr   = {8'h20, 8'h10};
    bus2.core_wdata = {8'h02, 8'h01};
    for (int s = 0; s < 7; s++) begin
      logic [1:0] eg;
      logic       et;
      drive2((s == 0) ? 2'b01 : ((s == 6) ? 2'b00 : 2'b11), 2'b00);
      @(posedge clk);
      #1;
      eg = 2'b01;
      et = 1'b0;
      if (s == 6) begin
        eg = 2'b00;
      end else if (s >= 4 && TO_EN) begin
        eg = 2'b10;
        et = (s == 4);
      end else begin
        eg = 2'b01;
      end
      chk($sformatf("to%0d grant", s),   32'(bus2.grant),   32'(eg));
      chk($sformatf("to%0d timeout", s), 32'(bus2.timeout), 32'(et));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an owned write
    drive2(2'b00, 2'b10);
    @(posedge clk);
    #1;
    chk("ar grant",     32'(bus2.grant),     32'h2);
    chk("ar mem_write", 32'(bus2.mem_write), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar grant drop", 32'(bus2.grant),     32'h0);
    chk("ar write drop", 32'(bus2.mem_write), 32'h0);
    chk("ar busy drop",  32'(bus2.busy),      32'h0);
    drive2(2'b00, 2'b00);
    @(negedge clk);
    reset = 1'b0;

    // Four cores: after core 0 has been served, requests 1011 rotate 1,3,0
    for (int s = 0; s < 6; s++) begin
      logic [3:0] rq [6];
      logic [3:0] eg [6];
      logic [1:0] eo [6];
      logic [7:0] ea [6];
      rq = '{4'b0001, 4'b0000, 4'b1011, 4'b1001, 4'b0001, 4'b0000};
      eg = '{4'b0001, 4'b0000, 4'b0010, 4'b1000, 4'b0001, 4'b0000};
      eo = '{2'd0,    2'd0,    2'd1,    2'd3,    2'd0,    2'd0};
      ea = '{8'hA0,   8'h00,   8'hB1,   8'hD3,   8'hA0,   8'h00};
      bus4.core_read = rq[s];
      @(posedge clk);
      #1;
      chk($sformatf("n4s%0d grant", s),   32'(bus4.grant),    32'(eg[s]));
      chk($sformatf("n4s%0d owner", s),   32'(bus4.owner),    32'(eo[s]));
      chk($sformatf("n4s%0d mem_adr", s), 32'(bus4.mem_adr),  32'(ea[s]));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
